// File: rtl/seq_chain_checker_pkg.sv
// Shared types and helpers for the sequence-chain checker.
//   chk_state_e : two-state tracker FSM encoding (IDLE, TRACK)
//   sat_inc     : saturating increment for counters up to SAT_MAX_W bits
package seq_chk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } chk_state_e;

  localparam int SAT_MAX_W = 32;

  // Increment val, holding at 2^width-1 instead of wrapping.
  // Bits above 'width' in val are expected to be zero.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int width);
    logic [SAT_MAX_W:0] lim;
    lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << width) - (SAT_MAX_W+1)'(1);
    if (val == lim[SAT_MAX_W-1:0]) begin
      return val;
    end
    return val + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_chain_checker_if.sv
// Control/status bundle of the sequence-chain checker.
//   enable, mode, ev, clear_counts : stimulus side (driven by master)
//   busy, step_idx, pass_pulse, fail_pulse, fail_step,
//   pass_count, fail_count         : status side (driven by slave = checker)
interface seq_chain_checker_if #(
  parameter int NUM_STEPS = 4,
  parameter int CNT_W     = 16
);
  localparam int SW = $clog2(NUM_STEPS);

  logic                 enable;
  logic                 mode;
  logic [NUM_STEPS-1:0] ev;
  logic                 clear_counts;
  logic                 busy;
  logic [SW-1:0]        step_idx;
  logic                 pass_pulse;
  logic                 fail_pulse;
  logic [SW-1:0]        fail_step;
  logic [CNT_W-1:0]     pass_count;
  logic [CNT_W-1:0]     fail_count;

  modport master (
    output enable, mode, ev, clear_counts,
    input  busy, step_idx, pass_pulse, fail_pulse, fail_step, pass_count, fail_count
  );

  modport slave (
    input  enable, mode, ev, clear_counts,
    output busy, step_idx, pass_pulse, fail_pulse, fail_step, pass_count, fail_count
  );
endinterface

// File: rtl/seq_chain_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clock, reset : clock and asynchronous active-high reset
//   inc          : count one event this edge
//   clr          : clear to zero this edge (wins over inc)
//   cnt          : current count, holds at 2^W-1
module sat_counter
  import seq_chk_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(SAT_MAX_W'(cnt_q), W));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_chain_checker.sv
// Ordered event-chain checker: ev[0] -> ev[1] -> ... -> ev[NUM_STEPS-1].
// Tracks one chain at a time; strict mode needs each step on the very next
// edge, windowed mode tolerates up to MAX_GAP-1 idle edges per step and fails
// on the MAX_GAP-th consecutive miss. Results are registered one-cycle pulses
// plus saturating pass/fail counters.
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : enable, mode, ev, clear_counts in;
//                  busy, step_idx, pass_pulse, fail_pulse, fail_step,
//                  pass_count, fail_count out
module seq_chain_checker
  import seq_chk_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int MAX_GAP   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  seq_chain_checker_if.slave  bus
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(MAX_GAP - 1);

  chk_state_e    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pass_pulse_q, pass_pulse_d;
  logic          fail_pulse_q, fail_pulse_d;
  logic [SW-1:0] fail_step_q, fail_step_d;
  logic          ev_sel;

  // Only the currently expected event matters; all others are ignored.
  always_comb begin
    ev_sel = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_q == SW'(i)) begin
        ev_sel = bus.ev[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    gap_d        = gap_q;
    pass_pulse_d = 1'b0;
    fail_pulse_d = 1'b0;
    fail_step_d  = fail_step_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && bus.ev[0]) begin
          state_d = TRACK;
          step_d  = SW'(1);
          gap_d   = '0;
        end
      end
      TRACK: begin
        if (!bus.enable) begin
          // Silent abort: no pulse, no count.
          state_d = IDLE;
          step_d  = '0;
          gap_d   = '0;
        end else if (ev_sel) begin
          gap_d = '0;
          if (step_q == LAST_STEP) begin
            pass_pulse_d = 1'b1;
            state_d      = IDLE;
            step_d       = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else if (bus.mode && (gap_q < GAP_LIMIT)) begin
          gap_d = gap_q + GW'(1);
        end else begin
          fail_pulse_d = 1'b1;
          fail_step_d  = step_q;
          state_d      = IDLE;
          step_d       = '0;
          gap_d        = '0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      gap_q        <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      fail_step_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      gap_q        <= gap_d;
      pass_pulse_q <= pass_pulse_d;
      fail_pulse_q <= fail_pulse_d;
      fail_step_q  <= fail_step_d;
    end
  end

  // Counters take the same-edge decision so they update alongside the pulses.
  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pass_pulse_d),
    .clr   (bus.clear_counts),
    .cnt   (bus.pass_count)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fail_pulse_d),
    .clr   (bus.clear_counts),
    .cnt   (bus.fail_count)
  );

  assign bus.busy       = (state_q == TRACK);
  assign bus.step_idx   = step_q;
  assign bus.pass_pulse = pass_pulse_q;
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_step  = fail_step_q;

endmodule

// File: tb/tb_seq_chain_checker.sv
// Bench for seq_chain_checker with NUM_STEPS=4, MAX_GAP=3, CNT_W=4.
module tb_seq_chain_checker;
  import seq_chk_pkg::*;

  logic clock;
  logic reset;

  seq_chain_checker_if #(.NUM_STEPS(4), .CNT_W(4)) bus ();

  seq_chain_checker #(.NUM_STEPS(4), .MAX_GAP(3), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       md;
    logic [3:0] ev;
    logic       clr;
    logic       busy;
    logic [1:0] step;
    logic       pp;
    logic       fp;
    logic [1:0] fs;
    logic [3:0] pc;
    logic [3:0] fc;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   vec_no = 0;
  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit md, logic [3:0] ev, bit clr,
                              bit busy, int step, bit pp, bit fp, int fs, int pc, int fc);
    vec_t v;
    v.en = en; v.md = md; v.ev = ev; v.clr = clr;
    v.busy = busy; v.step = 2'(step); v.pp = pp; v.fp = fp;
    v.fs = 2'(fs); v.pc = 4'(pc); v.fc = 4'(fc);
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector before the edge, score the outputs just after it.
  task automatic drive(input vec_t v);
    vec_t e;
    @(negedge clock);
    bus.enable       = v.en;
    bus.mode         = v.md;
    bus.ev           = v.ev;
    bus.clear_counts = v.clr;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("busy",       vec_no, 32'(bus.busy),       32'(e.busy));
    check("step_idx",   vec_no, 32'(bus.step_idx),   32'(e.step));
    check("pass_pulse", vec_no, 32'(bus.pass_pulse), 32'(e.pp));
    check("fail_pulse", vec_no, 32'(bus.fail_pulse), 32'(e.fp));
    check("fail_step",  vec_no, 32'(bus.fail_step),  32'(e.fs));
    check("pass_count", vec_no, 32'(bus.pass_count), 32'(e.pc));
    check("fail_count", vec_no, 32'(bus.fail_count), 32'(e.fc));
    vec_no++;
  endtask

  task automatic run_chain(input bit clr_last, input int pc_before, input int pc_after,
                           input int fc, input int fs);
    drive(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, fs, pc_before, fc));
    drive(mk(1, 0, 4'b0010, 0, 1, 2, 0, 0, fs, pc_before, fc));
    drive(mk(1, 0, 4'b0100, 0, 1, 3, 0, 0, fs, pc_before, fc));
    drive(mk(1, 0, 4'b1000, clr_last, 0, 0, 1, 0, fs, pc_after, clr_last ? 0 : fc));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       vec_no, 32'(bus.busy),       32'd0);
    check({tag, "_step_idx"},   vec_no, 32'(bus.step_idx),   32'd0);
    check({tag, "_pass_pulse"}, vec_no, 32'(bus.pass_pulse), 32'd0);
    check({tag, "_fail_pulse"}, vec_no, 32'(bus.fail_pulse), 32'd0);
    check({tag, "_fail_step"},  vec_no, 32'(bus.fail_step),  32'd0);
    check({tag, "_pass_count"}, vec_no, 32'(bus.pass_count), 32'd0);
    check({tag, "_fail_count"}, vec_no, 32'(bus.fail_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog vec=%0d got=timeout want=finish", vec_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // en md ev clr | busy step pp fp fs pc fc
    // strict pass
    tbl.push_back(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0010, 0, 1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0100, 0, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1000, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
    // strict fail at step 2
    tbl.push_back(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'b0010, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 1, 2, 1, 1));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 2, 1, 1));
    // windowed pass with 2 idle cycles, then fail on 3rd miss
    tbl.push_back(mk(1, 1, 4'b0001, 0, 1, 1, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 1, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 1, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 4'b0010, 0, 1, 2, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 4'b0100, 0, 1, 3, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 4'b1000, 0, 0, 0, 1, 0, 2, 2, 1));
    tbl.push_back(mk(1, 1, 4'b0001, 0, 1, 1, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 1, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 1, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0, 1, 1, 2, 2));
    tbl.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 2, 2));
    // ev[0] reasserted mid-chain is ignored; enable drop aborts silently
    tbl.push_back(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, 1, 2, 2));
    tbl.push_back(mk(1, 0, 4'b0011, 0, 1, 2, 0, 0, 1, 2, 2));
    tbl.push_back(mk(0, 0, 4'b0011, 0, 0, 0, 0, 0, 1, 2, 2));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0, 1, 2, 2));
    // other events ignored in window; mode switch to strict fails at once
    tbl.push_back(mk(1, 1, 4'b0001, 0, 1, 1, 0, 0, 1, 2, 2));
    tbl.push_back(mk(1, 1, 4'b1100, 0, 1, 1, 0, 0, 1, 2, 2));
    tbl.push_back(mk(1, 1, 4'b0011, 0, 1, 2, 0, 0, 1, 2, 2));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 1, 2, 2, 3));
    // immediate restart; ev[0] on the completing edge does not start a chain
    tbl.push_back(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, 2, 2, 3));
    tbl.push_back(mk(1, 0, 4'b0010, 0, 1, 2, 0, 0, 2, 2, 3));
    tbl.push_back(mk(1, 0, 4'b0100, 0, 1, 3, 0, 0, 2, 2, 3));
    tbl.push_back(mk(1, 0, 4'b1001, 0, 0, 0, 1, 0, 2, 3, 3));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 2, 3, 3));
    // clear both counters while idle
    tbl.push_back(mk(1, 0, 4'b0000, 1, 0, 0, 0, 0, 2, 0, 0));

    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.mode         = 1'b0;
    bus.ev           = '0;
    bus.clear_counts = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
    end

    // 17 passes: count saturates at 15
    for (int i = 0; i < 17; i++) begin
      run_chain(0, (i < 15) ? i : 15, (i + 1 < 15) ? i + 1 : 15, 0, 2);
    end
    // 18th pass with clear on the completing edge
    run_chain(1, 15, 0, 0, 2);

    // async reset mid-chain
    run_chain(0, 0, 1, 0, 2);
    drive(mk(1, 0, 4'b0001, 0, 1, 1, 0, 0, 2, 1, 0));
    drive(mk(1, 0, 4'b0010, 0, 1, 2, 0, 0, 2, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    bus.ev = '0;
    @(negedge clock);
    reset = 1'b0;
    run_chain(0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
